glitch_pipe: RTL and testbench
==============================

Name: glitch_pipe

Overview:
Parametrised, back-pressurable delay pipeline for the glitcher datapath, clocked by the glitched clock. It carries a data word and its valid flag through DEPTH register stages and adds a constant OFFSET on entry. A parity bit, captured at entry, is re-checked at exit so that register upsets caused by clock glitches are flagged and counted. It generalises the single-stage data/valid delay stage to configurable width and depth, with a ready handshake and fault detection.

Parameters:
WIDTH, 8, data word width in bits (1..64)
DEPTH, 4, number of register stages (1..16); latency in cycles with no stalls
OFFSET, 0, constant added to din at entry, modulo 2^WIDTH
CNT_W, 16, width of the error counter

Ports:
glitched_clk  in  1  sole clock; all state updates on its rising edge
rst  in  1  reset, asynchronous assert, active-low; deasserts synchronously to glitched_clk
din  in  WIDTH  input data word
din_valid  in  1  din is valid this cycle
din_ready  out  1  pipeline accepts din this cycle
dout  out  WIDTH  output data word (last stage)
dout_valid  out  1  dout is valid
dout_ready  in  1  downstream accepts dout this cycle
parity_err  out  1  one-cycle pulse: parity mismatch detected on an output transfer
err_count  out  CNT_W  saturating count of parity mismatches
clr_count  in  1  synchronous clear of err_count

Behaviour:
- One clock, glitched_clk. Reset is asynchronous and active-low (rst=0 resets). All flops clear immediately when rst=0.
- Reset values: every stage valid=0, data=0, parity=0; dout=0; dout_valid=0; parity_err=0; err_count=0. din_ready is combinational, so it is 1 once rst=1.
- Stage k (0..DEPTH-1) holds {valid_k, data_k, par_k}. Output ports take their values from stage DEPTH-1.
- Input transfer: din_valid && din_ready. Stage 0 loads data_0 = din + OFFSET (truncated to WIDTH) and par_0 = XOR-reduce of that sum.
- Output transfer: dout_valid && dout_ready.
- Advance rule: stage k may load when it is empty or when stage k+1 loads in the same cycle. The last stage is treated as loading when dout_ready=1. On load, stage k takes stage k-1's contents (stage 0 takes the input). A stage that loads from an invalid predecessor becomes invalid. This collapses bubbles.
- din_ready = !valid_0 || stage 1 loads (for DEPTH=1: !valid_0 || dout_ready). The path is combinational from dout_ready. No combinational path exists from din to dout.
- Latency: an accepted word appears on dout exactly DEPTH cycles after its input transfer when no stalls occur. Throughput is 1 word/cycle with dout_ready held at 1.
- Stall: with dout_ready=0, stages fill back to front. din_ready falls after at most DEPTH more accepted words. Held stage contents must not change while stalled.
- Ordering: words exit in input order. No loss and no duplication under any valid/ready pattern.
- Parity check: on each output transfer, if XOR-reduce(dout) != par_{DEPTH-1}, then parity_err=1 on the next cycle, otherwise 0. The word is still delivered unmodified.
- err_count increments by 1 on each detected mismatch (same cycle parity_err registers). It saturates at 2^CNT_W-1.
- clr_count=1 sets err_count to 0 next cycle and takes priority over a simultaneous increment. parity_err still pulses in that case.
- OFFSET arithmetic wraps: din = 2^WIDTH-1 with OFFSET=1 gives 0 with parity 0.
- Reset mid-operation: all in-flight words are discarded, and no parity_err is raised for them.

Test Plan:
1. WIDTH=8, DEPTH=4, OFFSET=0, dout_ready=1; stream din=0x01..0x10 on consecutive cycles -> dout=0x01..0x10 in order, first word 4 cycles after its input transfer, dout_valid continuous for 16 cycles, parity_err never set.
2. OFFSET=2; din=0xFF then 0x7E -> dout=0x01 then 0x80; no parity_err.
3. Hold dout_ready=0 while driving din_valid=1 with 0xA0,0xA1,... -> din_ready drops after exactly 4 accepted words. Then set dout_ready=1 for 1 of every 2 cycles -> outputs 0xA0,0xA1,... in order, none lost or duplicated.
4. Force (bench bit-flip) bit 0 of stage-2 data on a word 0x55 in flight -> dout=0x54, parity_err pulses 1 cycle after that transfer, err_count=1. A clean following word leaves err_count=1.
5. Inject mismatches with CNT_W=2 four times -> err_count sticks at 3. Assert clr_count in the same cycle as the next mismatch -> err_count=0 and parity_err=1.
6. Assert rst=0 asynchronously mid-stream with 3 words in flight -> dout_valid=0, dout=0, err_count=0 before the next clock edge. After release, the first new word 0x33 exits 4 cycles after its input transfer.

Source files
------------

// File: rtl/glitch_pipe.sv
// Back-pressurable DEPTH-stage delay pipeline: adds OFFSET on entry, tags each word with parity,
// re-checks parity at exit and keeps a saturating count of mismatches caused by register upsets.
module glitch_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned OFFSET = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             glitched_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            par_q;
    logic [DEPTH-1:0]            load;
    logic [WIDTH-1:0]            din_sum;
    logic                        out_xfer;
    logic                        mismatch;
    logic                        parity_err_q;
    logic [CNT_W-1:0]            err_count_q;

    assign din_sum = din + WIDTH'(OFFSET);

    // A stage loads when empty or when its successor loads; this ripples from dout_ready
    // back to stage 0 and collapses bubbles.
    always_comb begin
        logic chain;
        load  = '0;
        chain = dout_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            load[k] = !valid_q[k] || chain;
            chain   = load[k];
        end
    end

    assign din_ready = load[0];

    always_ff @(posedge glitched_clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            data_q  <= '0;
            par_q   <= '0;
        end else begin
            if (load[0]) begin
                valid_q[0] <= din_valid;
                data_q[0]  <= din_sum;
                par_q[0]   <= ^din_sum;
            end
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    data_q[k]  <= data_q[k-1];
                    par_q[k]   <= par_q[k-1];
                end
            end
        end
    end

    assign out_xfer = valid_q[DEPTH-1] && dout_ready;
    assign mismatch = out_xfer && ((^data_q[DEPTH-1]) != par_q[DEPTH-1]);

    // Clear wins over a simultaneous increment; the pulse itself is still reported.
    always_ff @(posedge glitched_clk or negedge rst) begin
        if (!rst) begin
            parity_err_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            parity_err_q <= mismatch;
            if (clr_count) begin
                err_count_q <= '0;
            end else if (mismatch && (err_count_q != {CNT_W{1'b1}})) begin
                err_count_q <= err_count_q + CNT_W'(1);
            end
        end
    end

    assign dout       = data_q[DEPTH-1];
    assign dout_valid = valid_q[DEPTH-1];
    assign parity_err = parity_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_glitch_pipe.sv
// Bench for glitch_pipe: two instances (OFFSET=0/CNT_W=16 and OFFSET=2/CNT_W=2) share stimulus
// and are compared every cycle against a queue-based model of order, latency and error counting.
module tb_glitch_pipe;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din;
    logic       din_valid, dout_ready, clr_count;
    logic       rdy_a, rdy_b, vld_a, vld_b, perr_a, perr_b;
    logic [7:0] dout_a, dout_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    glitch_pipe #(.WIDTH(8), .DEPTH(D), .OFFSET(0), .CNT_W(16)) dut_a (
        .glitched_clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_a),
        .dout(dout_a), .dout_valid(vld_a), .dout_ready(dout_ready), .parity_err(perr_a),
        .err_count(cnt_a), .clr_count(clr_count)
    );

    glitch_pipe #(.WIDTH(8), .DEPTH(D), .OFFSET(2), .CNT_W(2)) dut_b (
        .glitched_clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_b),
        .dout(dout_b), .dout_valid(vld_b), .dout_ready(dout_ready), .parity_err(perr_b),
        .err_count(cnt_b), .clr_count(clr_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: per instance, a ring of words in flight with their acceptance cycle and any
    // bit-flip injected by the bench. A word is visible at dout once DEPTH cycles have passed
    // since acceptance; occupancy alone decides whether input is accepted.
    logic [7:0] r_data[2][16];
    logic [7:0] r_mask[2][16];
    int         r_acc[2][16];
    int         r_head[2] = '{0, 0};
    int         r_cnt[2]  = '{0, 0};
    logic       exp_perr[2] = '{1'b0, 1'b0};
    int         m_cnt[2]  = '{0, 0};

    task automatic mark(input int inst, input int acc);
        for (int j = 0; j < r_cnt[inst]; j++) begin
            int p;
            p = (r_head[inst] + j) % 16;
            if (r_acc[inst][p] == acc) r_mask[inst][p] = r_mask[inst][p] ^ 8'h01;
        end
    endtask

    logic       a_rdy, a_vld, a_perr, e_vld, e_rdy, xfer, nperr;
    logic [7:0] a_dout, fmask;
    int         a_cnt, hd, tl;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            a_rdy  = (i == 0) ? rdy_a : rdy_b;
            a_vld  = (i == 0) ? vld_a : vld_b;
            a_perr = (i == 0) ? perr_a : perr_b;
            a_dout = (i == 0) ? dout_a : dout_b;
            a_cnt  = (i == 0) ? int'(cnt_a) : int'(cnt_b);
            if (!rst) begin
                check("reset_dout_valid", a_vld, 0);
                check("reset_dout", a_dout, 0);
                check("reset_parity_err", a_perr, 0);
                check("reset_err_count", a_cnt, 0);
                r_cnt[i]    = 0;
                exp_perr[i] = 1'b0;
                m_cnt[i]    = 0;
            end else begin
                hd    = r_head[i];
                e_vld = (r_cnt[i] > 0) && (cyc >= r_acc[i][hd] + D);
                e_rdy = (r_cnt[i] < D) || dout_ready;
                check("din_ready", a_rdy, e_rdy);
                check("dout_valid", a_vld, e_vld);
                check("parity_err", a_perr, exp_perr[i]);
                check("err_count", a_cnt, m_cnt[i]);
                if (e_vld) check("dout", a_dout, r_data[i][hd] ^ r_mask[i][hd]);
                xfer  = e_vld && dout_ready;
                fmask = r_mask[i][hd];
                nperr = xfer && (^fmask);
                if (xfer) begin
                    r_head[i] = (hd + 1) % 16;
                    r_cnt[i]  = r_cnt[i] - 1;
                end
                exp_perr[i] = nperr;
                if (clr_count) m_cnt[i] = 0;
                else if (nperr && m_cnt[i] < ((i == 0) ? 65535 : 3)) m_cnt[i] = m_cnt[i] + 1;
                if (din_valid && e_rdy) begin
                    tl = (r_head[i] + r_cnt[i]) % 16;
                    r_data[i][tl] = din + ((i == 0) ? 8'h00 : 8'h02);
                    r_mask[i][tl] = 8'h00;
                    r_acc[i][tl]  = cyc;
                    r_cnt[i]      = r_cnt[i] + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] flipv;

    // Send one word (followed by a bubble), flip bit 0 of it while it sits in stage 2, and
    // optionally assert clr_count in the cycle it leaves the pipeline.
    task automatic send_flip(input int inst, input logic [7:0] val, input bit clr_exit);
        int t0;
        din       = val;
        din_valid = 1'b1;
        t0        = cyc;
        step();
        din_valid = 1'b0;
        step();
        step();
        #1;
        if (inst == 0) begin
            flipv = dut_a.data_q[2] ^ 8'h01;
            force dut_a.data_q[2] = flipv;
        end else begin
            flipv = dut_b.data_q[2] ^ 8'h01;
            force dut_b.data_q[2] = flipv;
        end
        mark(inst, t0);
        step();
        if (inst == 0) release dut_a.data_q[2];
        else release dut_b.data_q[2];
        if (clr_exit) clr_count = 1'b1;
        step();
        clr_count = 1'b0;
    endtask

    initial begin
        int t0;
        int acc;
        bit tr;
        din        = 8'h00;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        clr_count  = 1'b0;
        #2 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("init_din_ready", rdy_a, 1);
        check("init_dout_valid", vld_a, 0);
        check("init_err_count", cnt_a, 0);

        // Streaming at full rate with OFFSET=0: first word four cycles after acceptance.
        t0 = cyc;
        for (int v = 1; v <= 16; v++) begin
            din       = 8'(v);
            din_valid = 1'b1;
            if (v == 4) check("t1_not_yet_valid", vld_a, 0);
            if (v == 5) begin
                check("t1_first_valid", vld_a, 1);
                check("t1_first_data", dout_a, 8'h01);
            end
            step();
        end
        din_valid = 1'b0;
        repeat (8) step();

        // Offset wrap on instance B.
        din = 8'hFF; din_valid = 1'b1;
        step();
        din = 8'h7E;
        step();
        din_valid = 1'b0;
        repeat (2) step();
        check("t2_wrap_b", dout_b, 8'h01);
        check("t2_plain_a", dout_a, 8'hFF);
        step();
        check("t2_second_b", dout_b, 8'h80);
        repeat (3) step();
        check("t2_no_perr", perr_b, 0);

        // Stall: exactly DEPTH words accepted, then half-rate drain.
        dout_ready = 1'b0;
        acc = 0;
        for (int n = 0; n < 10; n++) begin
            din       = 8'hA0 + 8'(acc);
            din_valid = 1'b1;
            #1;
            if (!rdy_a) break;
            step();
            acc++;
        end
        check("t3_accepted_before_full", acc, 4);
        for (int n = 0; n < 20; n++) begin
            dout_ready = n[0];
            #1;
            din = 8'hA0 + 8'(acc);
            tr  = din_valid && rdy_a;
            step();
            if (tr) acc++;
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (8) step();

        // Single upset on instance A, then a clean word.
        send_flip(0, 8'h55, 1'b0);
        check("t4_perr_pulse", perr_a, 1);
        check("t4_err_count", cnt_a, 1);
        din = 8'h66; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (6) step();
        check("t4_count_held", cnt_a, 1);
        check("t4_perr_clear", perr_a, 0);

        // Saturation of the 2-bit counter, then clear racing a mismatch.
        for (int k = 0; k < 4; k++) begin
            send_flip(1, 8'h10 + 8'(k), 1'b0);
            step();
        end
        check("t5_saturated", cnt_b, 3);
        send_flip(1, 8'h20, 1'b1);
        check("t5_clr_wins", cnt_b, 0);
        check("t5_perr_with_clr", perr_b, 1);
        repeat (3) step();

        // Asynchronous reset with three words in flight.
        send_flip(0, 8'h44, 1'b0);
        din_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = 8'h11 + 8'(k);
            step();
        end
        din_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("t6_async_valid", vld_a, 0);
        check("t6_async_dout", dout_a, 0);
        check("t6_async_count", cnt_a, 0);
        check("t6_async_valid_b", vld_b, 0);
        step();
        step();
        rst = 1'b1;
        din = 8'h33; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        step();
        check("t6_not_yet", vld_a, 0);
        step();
        check("t6_latency_valid", vld_a, 1);
        check("t6_latency_data", dout_a, 8'h33);
        repeat (4) step();

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            din        = 8'($urandom);
            din_valid  = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            clr_count  = ($urandom_range(0, 31) == 0);
            step();
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        clr_count  = 1'b0;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
